ram_to_notes: RTL

- Playback-side counterpart of the recording path.
- While master_state is PLAY (2'b10), walks the 128-entry song RAM from address 0 and decodes each 16-bit entry as a note event or a hold (rest) event.
- Sounds note events on up to 8 voices, each for its recorded number of beats.
- Drives the 48-bit notes bus to the synth and signals completion to lip_synth_master.

---
 rtl/song_pkg.sv | 23 ++
 rtl/ram_to_notes_if.sv | 10 +
 rtl/ram_to_notes_voice_slot.sv | 39 +++
 rtl/ram_to_notes.sv | 136 +++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared song-RAM definitions for the recording and playback paths.
package song_pkg;

    localparam logic [1:0] PLAY_STATE   = 2'b10;
    localparam logic [1:0] RECORD_STATE = 2'b01;

    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 10;
    localparam int DUR_MSB  = 9;
    localparam int DUR_LSB  = 0;

    localparam logic [15:0] END_WORD = 16'h0000;
    localparam int SONG_DEPTH = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_HOLD,
        ST_DONE
    } play_state_t;

endpackage

// File: rtl/ram_to_notes_if.sv
// Song RAM read port: registered address out, data back one cycle later.
interface ram_to_notes_if #(
    parameter int ADDR_W = 7
) ();
    logic [ADDR_W-1:0] read_address;
    logic [15:0]       read_data;

    modport master (output read_address, input read_data);
    modport slave  (input read_address, output read_data);
endinterface

// File: rtl/ram_to_notes_voice_slot.sv
// One playback voice: holds a note and counts its duration down in beats.
module voice_slot #(
    parameter int DUR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    input  logic             load,
    input  logic             clear,
    input  logic [5:0]       note_in,
    input  logic [DUR_W-1:0] dur_in,
    output logic [5:0]       note_out,
    output logic             active
);

    logic [DUR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            note_out <= '0;
            cnt      <= '0;
            active   <= 1'b0;
        end else if (load) begin
            note_out <= note_in;
            cnt      <= (dur_in == '0) ? DUR_W'(1) : dur_in;
            active   <= 1'b1;
        end else if (active && beat) begin
            // last beat frees the slot on this same edge
            if (cnt == DUR_W'(1)) begin
                note_out <= '0;
                cnt      <= '0;
                active   <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_to_notes.sv
// Song playback: walks the song RAM and sounds note events on a voice pool.
module ram_to_notes
    import song_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_W     = 7,
    parameter int DUR_W      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    beat,
    input  logic [1:0]              master_state,
    ram_to_notes_if.master          ram,
    output logic [6*NUM_VOICES-1:0] notes,
    output logic [NUM_VOICES-1:0]   voices_active,
    output logic                    start_playback,
    output logic                    finished_playback,
    output logic                    note_dropped
);

    play_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [DUR_W-1:0]  hold_cnt;

    logic              abort;
    logic              is_end;
    logic              is_note;
    logic              has_free;
    logic              want_voice;
    logic              found;
    logic [5:0]        rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic [NUM_VOICES-1:0] load_vec;

    logic              at_last;
    logic [ADDR_W-1:0] adv_addr;
    play_state_t       adv_state;

    assign ram.read_address = addr;

    assign rd_note  = ram.read_data[NOTE_MSB:NOTE_LSB];
    assign rd_dur   = ram.read_data[DUR_MSB:DUR_LSB];
    assign is_end   = (ram.read_data == END_WORD);
    assign is_note  = (rd_note != '0);
    assign has_free = ~&voices_active;

    assign abort = (state != ST_IDLE) && (master_state != PLAY_STATE);
    assign want_voice = (state == ST_DECODE) && is_note && !abort;

    // no wrap: the last entry ends the song
    assign at_last   = (addr == '1);
    assign adv_addr  = at_last ? addr : addr + 1'b1;
    assign adv_state = at_last ? ST_DONE : ST_FETCH;

    assign finished_playback = (state == ST_DONE) && (voices_active == '0);

    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!voices_active[i] && !found) begin
                load_vec[i] = want_voice;
                found       = 1'b1;
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot #(.DUR_W(DUR_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .beat     (beat),
            .load     (load_vec[v]),
            .clear    (abort),
            .note_in  (rd_note),
            .dur_in   (rd_dur),
            .note_out (notes[6*v +: 6]),
            .active   (voices_active[v])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            addr           <= '0;
            hold_cnt       <= '0;
            start_playback <= 1'b0;
            note_dropped   <= 1'b0;
        end else begin
            start_playback <= 1'b0;
            note_dropped   <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (master_state == PLAY_STATE) begin
                            start_playback <= 1'b1;
                            addr           <= '0;
                            state          <= ST_FETCH;
                        end
                    end
                    ST_FETCH: state <= ST_DECODE;
                    ST_DECODE: begin
                        if (is_end) begin
                            state <= ST_DONE;
                        end else if (is_note) begin
                            note_dropped <= !has_free;
                            addr         <= adv_addr;
                            state        <= adv_state;
                        end else if (rd_dur == '0) begin
                            addr  <= adv_addr;
                            state <= adv_state;
                        end else begin
                            hold_cnt <= rd_dur;
                            state    <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (beat) begin
                            hold_cnt <= hold_cnt - 1'b1;
                            if (hold_cnt == DUR_W'(1)) begin
                                addr  <= adv_addr;
                                state <= adv_state;
                            end
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
